// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared width, op codes, FSM states and iteration count for hilo_unit
package hilo_pkg;

  localparam int HILO_WIDTH = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_iter_step.sv
// rtl/hilo_iter_step.sv - one multiply (add-shift) or divide (compare-subtract-shift) iteration
// HILO_DIV_EN selects whether the divide branch exists.
module hilo_iter_step #(
  parameter int WIDTH = hilo_pkg::HILO_WIDTH
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             div_i,
  output logic [2*WIDTH:0] acc_o
);

  // Multiply: upper half accumulates, lower half holds the unconsumed multiplier bits.
  logic [WIDTH:0] add_sum;

  always_comb begin
    add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
  end

`ifdef HILO_DIV_EN
  // Divide: upper half is the partial remainder, quotient bits shift in at the bottom.
  logic [2*WIDTH:0] shl;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    shl  = {acc_i[2*WIDTH-1:0], 1'b0};
    diff = shl[2*WIDTH:WIDTH] - {1'b0, operand_i};
    fits = shl[2*WIDTH:WIDTH] >= {1'b0, operand_i};
    if (div_i) begin
      acc_o = fits ? {diff, shl[WIDTH-1:1], 1'b1} : shl;
    end else begin
      acc_o = {1'b0, add_sum, acc_i[WIDTH-1:1]};
    end
  end
`else
  logic unused_div;
  assign unused_div = div_i ^ acc_i[2*WIDTH];
  assign acc_o      = {1'b0, add_sum, acc_i[WIDTH-1:1]};
`endif

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning Hi/Lo and driving HiLoData
// Define HILO_DIV_EN to build the divider; otherwise DIV/DIVU starts are single-cycle no-ops.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic [WIDTH-1:0] writeData,
  input  logic             selHi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HiLoData
);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d, step_acc;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_res_q, neg_res_d;
  logic               done_q, done_d;
  logic               is_div, is_signed, a_neg, b_neg, launch, step_div;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
`ifdef HILO_DIV_EN
  logic               div_q, div_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic [WIDTH-1:0]   quo, rem;
`endif

  always_comb begin
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed & opA[WIDTH-1];
    b_neg     = is_signed & opB[WIDTH-1];
    mag_a     = a_neg ? -opA : opA;
    mag_b     = b_neg ? -opB : opB;
`ifdef HILO_DIV_EN
    launch    = start;
`else
    launch    = start & ~is_div;
`endif
  end

  // Sign-corrected results, consumed only in FIX.
  always_comb begin
    prod = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
`ifdef HILO_DIV_EN
    quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  end

`ifdef HILO_DIV_EN
  assign step_div = div_q;
`else
  assign step_div = 1'b0;
`endif

  hilo_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .div_i     (step_div),
    .acc_o     (step_acc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef HILO_DIV_EN
    div_d     = div_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (writeHi) hi_d = writeData;
        if (writeLo) lo_d = writeData;
        if (launch) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          acc_d     = {{(WIDTH+1){1'b0}}, mag_a};
          operand_d = mag_b;
          neg_res_d = a_neg ^ b_neg;
`ifdef HILO_DIV_EN
          div_d     = is_div;
          neg_rem_d = a_neg;
          dz_d      = (opB == '0);
`endif
        end
`ifndef HILO_DIV_EN
        if (start && is_div) done_d = 1'b1;
`endif
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER_COUNT - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        hi_d    = prod[2*WIDTH-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
`ifdef HILO_DIV_EN
        // Divide by zero leaves the remainder as opA naturally; only the quotient is forced.
        if (div_q) begin
          hi_d = rem;
          lo_d = dz_q ? '1 : quo;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef HILO_DIV_EN
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef HILO_DIV_EN
      div_q     <= div_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
`endif
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign HiLoData = selHi ? hi_q : lo_q;

endmodule
